// File: rtl/sr_pulse_ctrl.sv
// Driver stage for a cross-coupled NOR SR latch: turns single-cycle set/clear
// requests into exclusive fixed-width s/r pulses and checks the latch feedback.
module sr_pulse_ctrl #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic err_clr,
    input  logic q_in,
    input  logic q1_in,
    output logic s,
    output logic r,
    output logic busy,
    output logic state_exp,
    output logic err
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_PULSE,
        ST_GAP,
        ST_IDLE
    } state_t;

    // s and r are decoded from this single register, so they cannot both be high.
    typedef enum logic [1:0] {
        DRV_NONE,
        DRV_SET,
        DRV_CLR
    } drive_t;

    state_t           state_q,     state_d;
    drive_t           drive_q,     drive_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             state_exp_q, state_exp_d;
    logic             err_q,       err_d;
    logic             mismatch;

    logic q_meta, q_sync;
    logic q1_meta, q1_sync;

    // Two-flop synchronisers for the latch outputs, which are asynchronous to clk.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which a synchroniser chain relies on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta  <= 1'b0;
            q_sync  <= 1'b0;
            q1_meta <= 1'b0;
            q1_sync <= 1'b0;
        end else begin
            q_meta  <= q_in;
            q_sync  <= q_meta;
            q1_meta <= q1_in;
            q1_sync <= q1_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            drive_q     <= DRV_NONE;
            cnt_q       <= CNT_ZERO;
            state_exp_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            drive_q     <= drive_d;
            cnt_q       <= cnt_d;
            state_exp_q <= state_exp_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        drive_d     = drive_q;
        cnt_d       = cnt_q;
        state_exp_d = state_exp_q;
        mismatch    = 1'b0;

        case (state_q)
            ST_INIT: begin
                // Power-up / post-reset clear pulse puts the latch in a known state.
                state_d = ST_PULSE;
                drive_d = DRV_CLR;
                cnt_d   = PULSE_LOAD;
            end

            ST_IDLE: begin
                drive_d = DRV_NONE;
                if (set_req && !clr_req) begin
                    state_d     = ST_PULSE;
                    drive_d     = DRV_SET;
                    cnt_d       = PULSE_LOAD;
                    state_exp_d = 1'b1;
                end else if (clr_req && !set_req) begin
                    state_d     = ST_PULSE;
                    drive_d     = DRV_CLR;
                    cnt_d       = PULSE_LOAD;
                    state_exp_d = 1'b0;
                end
            end

            ST_PULSE: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_GAP;
                    drive_d = DRV_NONE;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_GAP: begin
                drive_d = DRV_NONE;
                if (cnt_q == CNT_ZERO) begin
                    // The gap is long enough for the latch outputs to cross the synchroniser.
                    mismatch = (q_sync != state_exp_q) || (q1_sync != ~state_exp_q);
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_INIT;
                drive_d = DRV_NONE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // A fresh mismatch outranks a simultaneous clear so no error is ever lost.
    always_comb begin
        err_d = err_q;
        if (mismatch) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    assign s         = (drive_q == DRV_SET);
    assign r         = (drive_q == DRV_CLR);
    assign busy      = (state_q != ST_IDLE);
    assign state_exp = state_exp_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// Self-checking bench for sr_pulse_ctrl with a behavioural NOR-latch model and
// a scoreboard of expected latch state / error flag per accepted pulse.
module tb_sr_pulse_ctrl;

    localparam int PULSE_W = 4;
    localparam int GAP_W   = 3;

    typedef struct packed {
        logic st;
        logic er;
    } sb_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic err_clr = 1'b0;
    logic q_in, q1_in;
    logic s, r, busy, state_exp, err;

    logic lq    = 1'b1;
    logic stuck = 1'b0;

    logic model_state = 1'b0;
    logic model_err   = 1'b0;
    sb_t  sb[$];

    int compared   = 0;
    int mismatched = 0;

    sr_pulse_ctrl #(
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_req   (set_req),
        .clr_req   (clr_req),
        .err_clr   (err_clr),
        .q_in      (q_in),
        .q1_in     (q1_in),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .state_exp (state_exp),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural NOR latch; the stuck control pins q low to provoke mismatches.
    always @(s or r) begin
        if (s && !r) lq = 1'b1;
        else if (r && !s) lq = 1'b0;
    end
    assign q_in  = lq & ~stuck;
    assign q1_in = ~lq;

    always @(negedge clk) begin
        compared++;
        assert (!(s && r)) else begin
            mismatched++;
            $error("FAIL s_r_exclusive: observed s=%b r=%b required not both 1", s, r);
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called just after the accepting edge E; returns just after edge E+PULSE_W+GAP_W.
    task automatic pulse_body(input string tag, input logic exp_s, input logic inj_clr,
                              input logic ec_cmp, input logic err_before);
        sb_t e;
        for (int i = 0; i < PULSE_W; i++) begin
            check({tag, "_pulse_s"}, s, exp_s);
            check({tag, "_pulse_r"}, r, ~exp_s);
            check({tag, "_pulse_busy"}, busy, 1'b1);
            check({tag, "_pulse_state_exp"}, state_exp, model_state);
            check({tag, "_pulse_err"}, err, err_before);
            if (inj_clr) clr_req = (i == 1);
            step();
        end
        clr_req = 1'b0;
        for (int j = 0; j < GAP_W; j++) begin
            check({tag, "_gap_s"}, s, 1'b0);
            check({tag, "_gap_r"}, r, 1'b0);
            check({tag, "_gap_busy"}, busy, 1'b1);
            check({tag, "_gap_err"}, err, err_before);
            if (ec_cmp) err_clr = (j == GAP_W - 1);
            step();
        end
        err_clr = 1'b0;
        check({tag, "_done_busy"}, busy, 1'b0);
        check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_state_exp"}, state_exp, e.st);
            check({tag, "_err"}, err, e.er);
        end
    endtask

    task automatic request(input string tag, input logic sr, input logic cr,
                           input logic inj_clr, input logic ec_cmp);
        logic accept;
        logic err_before;
        logic mism;
        accept     = sr ^ cr;
        err_before = model_err;
        set_req    = sr;
        clr_req    = cr;
        if (accept) begin
            model_state = sr;
            mism        = stuck && model_state;
            if (mism) model_err = 1'b1;
            else if (ec_cmp) model_err = 1'b0;
            sb.push_back('{model_state, model_err});
        end
        step();
        set_req = 1'b0;
        clr_req = 1'b0;
        if (accept) begin
            pulse_body(tag, sr, inj_clr, ec_cmp, err_before);
        end else begin
            for (int k = 0; k < 3; k++) begin
                check({tag, "_idle_busy"}, busy, 1'b0);
                check({tag, "_idle_s"}, s, 1'b0);
                check({tag, "_idle_r"}, r, 1'b0);
                check({tag, "_idle_state_exp"}, state_exp, model_state);
                check({tag, "_idle_err"}, err, model_err);
                step();
            end
        end
    endtask

    initial begin
        int kind;

        step();
        check("rst_s", s, 1'b0);
        check("rst_r", r, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_state_exp", state_exp, 1'b0);
        check("rst_err", err, 1'b0);

        rst_n = 1'b1;
        sb.push_back('{1'b0, 1'b0});
        step();
        pulse_body("init", 1'b0, 1'b0, 1'b0, 1'b0);
        check("init_latch_q", q_in, 1'b0);

        request("set", 1'b1, 1'b0, 1'b0, 1'b0);
        check("set_latch_q", q_in, 1'b1);
        check("set_latch_q1", q1_in, 1'b0);

        request("both", 1'b1, 1'b1, 1'b0, 1'b0);
        request("none", 1'b0, 1'b0, 1'b0, 1'b0);
        request("set_late_clr", 1'b1, 1'b0, 1'b1, 1'b0);
        request("clr", 1'b0, 1'b1, 1'b0, 1'b0);
        check("clr_latch_q", q_in, 1'b0);
        check("clr_latch_q1", q1_in, 1'b1);

        stuck = 1'b1;
        request("stuck_set", 1'b1, 1'b0, 1'b0, 1'b0);
        err_clr = 1'b1;
        step();
        err_clr   = 1'b0;
        model_err = 1'b0;
        check("err_clr_idle", err, 1'b0);
        request("stuck_clr_race", 1'b1, 1'b0, 1'b0, 1'b1);
        stuck = 1'b0;
        request("clr_sticky", 1'b0, 1'b1, 1'b0, 1'b0);
        err_clr = 1'b1;
        step();
        err_clr   = 1'b0;
        model_err = 1'b0;
        check("err_clr_again", err, 1'b0);

        for (int n = 0; n < 16; n++) begin
            kind = $urandom_range(0, 3);
            request("rand", (kind == 1) || (kind == 3), (kind == 2) || (kind == 3), 1'b0, 1'b0);
        end

        // Leave err set, then reset in the middle of a set pulse.
        stuck = 1'b1;
        request("pre_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        stuck = 1'b0;
        set_req = 1'b1;
        step();
        set_req = 1'b0;
        check("mid_s_before_rst", s, 1'b1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_s", s, 1'b0);
        check("async_rst_r", r, 1'b0);
        check("async_rst_busy", busy, 1'b1);
        check("async_rst_state_exp", state_exp, 1'b0);
        check("async_rst_err", err, 1'b0);
        model_state = 1'b0;
        model_err   = 1'b0;
        step();
        check("held_rst_r", r, 1'b0);
        rst_n = 1'b1;
        sb.push_back('{1'b0, 1'b0});
        step();
        pulse_body("reinit", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reinit_latch_q", q_in, 1'b0);
        request("post_rst_set", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sr_pulse_ctrl.md
# sr_pulse_ctrl

Synchronous driver stage that sits directly upstream of the cross-coupled NOR SR latch and generates its `s`/`r` inputs. Converts single-cycle set/clear requests into mutually exclusive, fixed-width pulses with a guard gap, so the latch never sees the forbidden `s=r=1` condition. Resynchronises the latch's `q`/`q1` feedback and flags any mismatch against the expected latch state. Forces the latch to a known cleared state after every reset.

## Interface
- `PULSE_W`, 4: cycles `s` or `r` is held high per pulse; legal range ≥1.
- `GAP_W`, 3: idle cycles after each pulse before a new request is accepted; legal range ≥3, to cover the 2-flop sync plus 1 compare cycle.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `set_req`  in  1  request latch set; sampled only in IDLE.
- `clr_req`  in  1  request latch clear; sampled only in IDLE.
- `err_clr`  in  1  clears sticky `err`.
- `q_in`  in  1  latch `q` output (asynchronous to `clk`).
- `q1_in`  in  1  latch `q1` output (asynchronous to `clk`).
- `s`  out  1  latch set drive, registered.
- `r`  out  1  latch reset drive, registered.
- `busy`  out  1  high while not in IDLE.
- `state_exp`  out  1  expected latch `q`.
- `err`  out  1  sticky feedback-mismatch flag.

## Operation
- FSM states: INIT, PULSE, GAP, IDLE. One down-counter, width `$clog2(max(PULSE_W,GAP_W)+1)`.
- Reset values (asynchronous): FSM=INIT, `s`=0, `r`=0, `busy`=1, `state_exp`=0, `err`=0, sync flops=0, counter=0.
- INIT: on the first edge with `rst_n`=1, go to PULSE with `r`=1 and counter=`PULSE_W`-1. `state_exp` stays 0.
- IDLE handling:
  - `set_req`=1, `clr_req`=0: go to PULSE with `s`=1; `state_exp`←1 on the same edge.
  - `clr_req`=1, `set_req`=0: go to PULSE with `r`=1; `state_exp`←0.
  - Both high, or neither: stay IDLE. No pulse; `state_exp` is unchanged.
  - A request matching the current `state_exp` still issues a pulse (refresh).
- PULSE: hold `s`/`r`. On the edge where counter=0, drive `s`=`r`=0, load counter=`GAP_W`-1, go to GAP. Otherwise decrement.
- GAP: `s`=`r`=0. On the edge where counter=0:
  - Compare synced feedback. Mismatch if `q_sync`≠`state_exp` or `q1_sync`≠~`state_exp`; a mismatch sets `err`.
  - Go to IDLE.
- `s` and `r` are never both 1 in any cycle. They come from the same one-hot-decoded state register.
- Requests arriving in INIT, PULSE or GAP are ignored. There is no queueing.
- `err` is sticky. `err_clr` clears it in any state. If a new mismatch and `err_clr` occur on the same edge, set wins.
- `q_in`/`q1_in` each pass through a 2-flop synchroniser before use.
- Reset mid-operation: `s`/`r` drop to 0 asynchronously and the FSM restarts in INIT. `state_exp`=0 and `err`=0.

## Timing
- Request accepted at edge E: `s`/`r` high from E through E+`PULSE_W`; low from edge E+`PULSE_W`.
- GAP covers `GAP_W` cycles. The feedback compare and `err` update occur at edge E+`PULSE_W`+`GAP_W`, and IDLE is entered on that same edge.
- `busy` rises at edge E and falls at E+`PULSE_W`+`GAP_W`. The next request is sampled at the following edge.
- Minimum request-to-request spacing: `PULSE_W`+`GAP_W`+1 cycles.
- After reset release, the first edge starts the INIT clear pulse. `busy` stays 1 until that pulse's GAP completes, i.e. `PULSE_W`+`GAP_W` edges after the first active edge.

## Test plan
- Reset release, defaults, latch model attached:
  - `r`=1 for exactly 4 cycles, then 3 gap cycles.
  - `busy` falls at edge 7; `state_exp`=0, `err`=0.
- Idle, `set_req` pulse one cycle at edge E:
  - `s`=1 during E..E+3, `r`=0 throughout, `state_exp`=1 from E.
  - Latch `q`=1 and `q1`=0; `err` stays 0; `busy` low after E+7.
- `set_req`=`clr_req`=1 together in IDLE: no pulse, `busy` stays 0, `state_exp` unchanged.
- `clr_req` issued 2 cycles after an accepted `set_req`: ignored, and only the set pulse appears. A later `clr_req` in IDLE gives `r` high for 4 cycles and `state_exp`=0.
- Latch model with `q` stuck at 0:
  - Set request gives `err`=1 at edge E+7.
  - `err_clr` pulsed in IDLE gives `err`=0.
  - `err_clr` on the same edge as a new mismatch leaves `err`=1.
- Random stream of set/clr/both requests plus `rst_n` asserted mid-PULSE:
  - Assertion `!(s && r)` never fires.
  - `s`/`r` fall asynchronously to 0 on reset, and the INIT clear pulse recurs on release.
